// File: rtl/csa_op_sequencer_if.sv
// Request, result and adder-side signals of the carry-select adder operand sequencer.
// The sequencer takes the slave modport; the environment takes master.
interface csa_op_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_sub;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_sum;
   logic        res_cout;
   logic        res_overf;
   logic        res_timeout;
   logic [63:0] csa_ope1;
   logic [63:0] csa_ope2;
   logic        csa_add_sub;
   logic        csa_start;
   logic        csa_complete;
   logic [63:0] csa_sum;
   logic        csa_cout;
   logic        csa_overf;

   modport master (
      output in_valid, in_a, in_b, in_sub, res_ready,
             csa_complete, csa_sum, csa_cout, csa_overf,
      input  in_ready, res_valid, res_sum, res_cout, res_overf, res_timeout,
             csa_ope1, csa_ope2, csa_add_sub, csa_start
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, res_ready,
             csa_complete, csa_sum, csa_cout, csa_overf,
      output in_ready, res_valid, res_sum, res_cout, res_overf, res_timeout,
             csa_ope1, csa_ope2, csa_add_sub, csa_start
   );
endinterface

// File: rtl/csa_op_sequencer.sv
// Operand-issue / result-capture front end for the 64-bit carry-select adder:
// request FIFO, one-at-a-time issue FSM, result holding register and watchdog.
module csa_op_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   csa_op_sequencer_if.slave      bus,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
   } req_t;

   req_t          mem [DEPTH];
   req_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_nxt;
   logic          push;
   logic          pop;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [63:0]   ope1_nxt;
   logic [63:0]   ope2_nxt;
   logic          add_sub_nxt;
   logic          start_nxt;
   logic          rv_nxt;
   logic [63:0]   sum_nxt;
   logic          cout_nxt;
   logic          overf_nxt;
   logic          to_nxt;

   assign push      = bus.in_valid && bus.in_ready;
   assign head      = mem[rd_ptr];
   assign count_nxt = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

   // Storage has no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_sub};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         bus.in_ready <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count   <= count_nxt;
         bus.in_ready <= (count_nxt != (AW+1)'(DEPTH));
      end
   end

   // Issue FSM next-state and registered-output values.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ope1_nxt    = bus.csa_ope1;
      ope2_nxt    = bus.csa_ope2;
      add_sub_nxt = bus.csa_add_sub;
      start_nxt   = 1'b0;
      rv_nxt      = bus.res_valid;
      sum_nxt     = bus.res_sum;
      cout_nxt    = bus.res_cout;
      overf_nxt   = bus.res_overf;
      to_nxt      = bus.res_timeout;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop         = 1'b1;
               ope1_nxt    = head.a;
               ope2_nxt    = head.b;
               add_sub_nxt = head.sub;
               start_nxt   = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            // A complete in the start cycle belongs to no issued operation.
            if (!bus.csa_start && bus.csa_complete) begin
               sum_nxt   = bus.csa_sum;
               cout_nxt  = bus.csa_cout;
               overf_nxt = bus.csa_overf;
               to_nxt    = 1'b0;
               rv_nxt    = 1'b1;
               state_nxt = HOLD;
            end else begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == CW'(TIMEOUT - 1)) begin
                  sum_nxt   = '0;
                  cout_nxt  = 1'b0;
                  overf_nxt = 1'b0;
                  to_nxt    = 1'b1;
                  rv_nxt    = 1'b1;
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.res_ready) begin
               rv_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.csa_ope1    <= '0;
         bus.csa_ope2    <= '0;
         bus.csa_add_sub <= 1'b0;
         bus.csa_start   <= 1'b0;
         bus.res_valid   <= 1'b0;
         bus.res_sum     <= '0;
         bus.res_cout    <= 1'b0;
         bus.res_overf   <= 1'b0;
         bus.res_timeout <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         bus.csa_ope1    <= ope1_nxt;
         bus.csa_ope2    <= ope2_nxt;
         bus.csa_add_sub <= add_sub_nxt;
         bus.csa_start   <= start_nxt;
         bus.res_valid   <= rv_nxt;
         bus.res_sum     <= sum_nxt;
         bus.res_cout    <= cout_nxt;
         bus.res_overf   <= overf_nxt;
         bus.res_timeout <= to_nxt;
         busy            <= (state_nxt != IDLE) || (count_nxt != '0);
      end
   end
endmodule

// File: tb/tb_csa_op_sequencer.sv
// Directed bench for csa_op_sequencer with a behavioural carry-select adder on
// the csa_* side whose latency, enable and stray-complete injection are controllable.
module tb_csa_op_sequencer;
   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] fifo_count;
   logic       busy;

   csa_op_sequencer_if bif ();

   csa_op_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bif),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   int model_lat = 3;
   bit model_en  = 1'b1;
   bit stray     = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b, input logic s);
      bif.in_valid = 1'b1;
      bif.in_a     = a;
      bif.in_b     = b;
      bif.in_sub   = s;
      tick();
      bif.in_valid = 1'b0;
   endtask

   task automatic wait_res(input int max, output int n);
      n = 0;
      while (!bif.res_valid && n < max) begin
         tick();
         n++;
      end
      check("res_arrived", 64'(bif.res_valid), 64'd1);
   endtask

   task automatic accept();
      bif.res_ready = 1'b1;
      tick();
      bif.res_ready = 1'b0;
   endtask

   // Adder model, acting 2 time units after each edge so it never races the main sequence.
   initial begin
      int          cd;
      logic [63:0] bb;
      logic [64:0] r;
      cd = 0;
      bif.csa_complete = 1'b0;
      bif.csa_sum      = '0;
      bif.csa_cout     = 1'b0;
      bif.csa_overf    = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         bif.csa_complete = stray;
         if (cd > 0) begin
            cd--;
            if (cd == 1) begin
               bb = bif.csa_add_sub ? ~bif.csa_ope2 : bif.csa_ope2;
               r  = {1'b0, bif.csa_ope1} + {1'b0, bb} + 65'(bif.csa_add_sub);
               bif.csa_sum      = r[63:0];
               bif.csa_cout     = r[64];
               bif.csa_overf    = (bif.csa_ope1[63] == bb[63]) && (r[63] != bif.csa_ope1[63]);
               bif.csa_complete = 1'b1;
            end
         end
         if (bif.csa_start) begin
            start_cnt++;
            if (model_en) cd = model_lat;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n;
      int          base;
      logic [63:0] o1;
      logic [63:0] o2;
      logic        os;
      bit          stable;
      logic [63:0] exp_fill [5];
      logic [63:0] exp_wrap [3];
      exp_fill[0] = 64'h11; exp_fill[1] = 64'h22; exp_fill[2] = 64'h33;
      exp_fill[3] = 64'h44; exp_fill[4] = 64'h55;
      exp_wrap[0] = 64'h202; exp_wrap[1] = 64'h303; exp_wrap[2] = 64'h404;

      reset = 1'b1;
      bif.in_valid  = 1'b0;
      bif.in_a      = '0;
      bif.in_b      = '0;
      bif.in_sub    = 1'b0;
      bif.res_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready",   64'(bif.in_ready),    64'd1);
      check("rst_res_valid",  64'(bif.res_valid),   64'd0);
      check("rst_start",      64'(bif.csa_start),   64'd0);
      check("rst_fifo_count", 64'(fifo_count),      64'd0);
      check("rst_busy",       64'(busy),            64'd0);
      check("rst_res_sum",    bif.res_sum,          64'd0);
      reset = 1'b0;

      // Single add with 3-cycle adder latency.
      push(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      check("add_count_after_push", 64'(fifo_count), 64'd1);
      check("add_no_start_yet", 64'(bif.csa_start), 64'd0);
      check("add_busy", 64'(busy), 64'd1);
      tick();
      check("add_start", 64'(bif.csa_start), 64'd1);
      check("add_ope1", bif.csa_ope1, 64'h0000_0000_FFFF_FFFF);
      check("add_ope2", bif.csa_ope2, 64'd1);
      check("add_count_after_pop", 64'(fifo_count), 64'd0);
      tick();
      check("add_start_pulse", 64'(bif.csa_start), 64'd0);
      wait_res(20, n);
      check("add_latency", 64'(n), 64'd2);
      check("add_sum", bif.res_sum, 64'h0000_0001_0000_0000);
      check("add_cout", 64'(bif.res_cout), 64'd0);
      check("add_overf", 64'(bif.res_overf), 64'd0);
      check("add_timeout", 64'(bif.res_timeout), 64'd0);
      tick();
      check("add_hold_valid", 64'(bif.res_valid), 64'd1);
      check("add_hold_sum", bif.res_sum, 64'h0000_0001_0000_0000);
      accept();
      check("add_accepted", 64'(bif.res_valid), 64'd0);
      check("add_idle", 64'(busy), 64'd0);

      // Fill the FIFO behind an unaccepted result; then drain in order.
      base = start_cnt;
      push(64'h10, 64'd1, 1'b0);
      wait_res(20, n);
      for (int k = 1; k < 5; k++) begin
         push(64'h10 * 64'(k + 1), 64'(k + 1), 1'b0);
         check("fill_count", 64'(fifo_count), 64'(k));
      end
      check("fill_full", 64'(bif.in_ready), 64'd0);
      bif.in_valid = 1'b1;
      bif.in_a     = 64'h999;
      bif.in_b     = 64'h1;
      tick();
      bif.in_valid = 1'b0;
      check("fill_reject_count", 64'(fifo_count), 64'd4);
      for (int k = 0; k < 5; k++) begin
         wait_res(20, n);
         check("fill_sum", bif.res_sum, exp_fill[k]);
         accept();
      end
      check("fill_starts", 64'(start_cnt - base), 64'd5);
      check("fill_drained", 64'(busy), 64'd0);

      // Push coinciding with pop, entries crossing the pointer wrap.
      push(64'h100, 64'h1, 1'b0);
      wait_res(20, n);
      check("wrap_s0_sum", bif.res_sum, 64'h101);
      push(64'h200, 64'h2, 1'b0);
      push(64'h300, 64'h3, 1'b0);
      check("wrap_count2", 64'(fifo_count), 64'd2);
      accept();
      bif.in_valid = 1'b1;
      bif.in_a     = 64'h400;
      bif.in_b     = 64'h4;
      bif.in_sub   = 1'b0;
      tick();
      bif.in_valid = 1'b0;
      check("wrap_push_pop_count", 64'(fifo_count), 64'd2);
      check("wrap_start", 64'(bif.csa_start), 64'd1);
      check("wrap_ope1", bif.csa_ope1, 64'h200);
      for (int k = 0; k < 3; k++) begin
         wait_res(20, n);
         check("wrap_sum", bif.res_sum, exp_wrap[k]);
         accept();
      end
      check("wrap_empty", 64'(fifo_count), 64'd0);

      // Watchdog abort, then stray completes in HOLD and IDLE.
      model_en = 1'b0;
      push(64'h1234, 64'h1, 1'b0);
      tick();
      check("to_start", 64'(bif.csa_start), 64'd1);
      wait_res(100, n);
      check("to_latency", 64'(n), 64'd64);
      check("to_flag", 64'(bif.res_timeout), 64'd1);
      check("to_sum", bif.res_sum, 64'd0);
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      check("to_stray_hold_valid", 64'(bif.res_valid), 64'd1);
      check("to_stray_hold_flag", 64'(bif.res_timeout), 64'd1);
      check("to_stray_hold_sum", bif.res_sum, 64'd0);
      accept();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      check("to_stray_idle_valid", 64'(bif.res_valid), 64'd0);
      check("to_stray_idle_busy", 64'(busy), 64'd0);
      check("to_stray_idle_start", 64'(bif.csa_start), 64'd0);
      model_en = 1'b1;

      // Subtract with operand stability from start until acceptance.
      model_lat = 5;
      push(64'd5, 64'd7, 1'b1);
      tick();
      check("sub_start", 64'(bif.csa_start), 64'd1);
      o1 = bif.csa_ope1;
      o2 = bif.csa_ope2;
      os = bif.csa_add_sub;
      stable = 1'b1;
      for (int i = 0; i < 20 && !bif.res_valid; i++) begin
         tick();
         if (bif.csa_ope1 !== o1 || bif.csa_ope2 !== o2 || bif.csa_add_sub !== os) stable = 1'b0;
      end
      check("sub_arrived", 64'(bif.res_valid), 64'd1);
      tick();
      if (bif.csa_ope1 !== o1 || bif.csa_ope2 !== o2 || bif.csa_add_sub !== os) stable = 1'b0;
      check("sub_ops_stable", 64'(stable), 64'd1);
      check("sub_ope1", o1, 64'd5);
      check("sub_ope2", o2, 64'd7);
      check("sub_add_sub", 64'(os), 64'd1);
      check("sub_sum", bif.res_sum, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_cout", 64'(bif.res_cout), 64'd0);
      check("sub_overf", 64'(bif.res_overf), 64'd0);
      accept();

      // Reset during WAIT with two entries queued.
      model_lat = 10;
      push(64'h1, 64'h1, 1'b0);
      tick();
      check("rw_start", 64'(bif.csa_start), 64'd1);
      push(64'h2, 64'h2, 1'b0);
      push(64'h3, 64'h3, 1'b0);
      check("rw_queued", 64'(fifo_count), 64'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rw_count", 64'(fifo_count), 64'd0);
      check("rw_valid", 64'(bif.res_valid), 64'd0);
      check("rw_start_low", 64'(bif.csa_start), 64'd0);
      check("rw_busy", 64'(busy), 64'd0);
      check("rw_in_ready", 64'(bif.in_ready), 64'd1);
      base = start_cnt;
      for (int i = 0; i < 12; i++) tick();
      check("rw_late_valid", 64'(bif.res_valid), 64'd0);
      check("rw_late_busy", 64'(busy), 64'd0);
      check("rw_no_reissue", 64'(start_cnt - base), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
